rect_draw_ctrl: RTL
===================

// Module: rect_draw_ctrl
// PURPOSE
//  Parametrised rectangle plotter for the VGA adapter. Latches origin, size and colour on a
//  start request, or the full screen and CLR_COLOUR on a clear request. Then emits one pixel
//  write per clock in raster order, with internal counters, screen clipping and ready/busy/done
//  handshakes. Sits between game/sequence logic and the vga_adapter plot port.
// PARAMETERS
//  X_W        8    x coordinate/width bits
//  Y_W        7    y coordinate/height bits
//  COLOUR_W   3    colour bits
//  SCREEN_W   160  visible columns; must be <= 2**X_W-1
//  SCREEN_H   120  visible rows; must be <= 2**Y_W-1
//  CLR_COLOUR 0    colour used by clear
// PORTS
//  clk         in  1         clock
//  resetn      in  1         reset, synchronous, active-low
//  start       in  1         draw request; sampled only when ready=1
//  clear       in  1         clear-screen request; sampled only when ready=1
//  x_in,y_in   in  X_W,Y_W   rectangle origin (top-left)
//  w_in,h_in   in  X_W,Y_W   rectangle width/height in pixels
//  colour_in   in  COLOUR_W  fill colour
//  ready       out 1         idle, request will be accepted
//  busy        out 1         request in progress (=!ready)
//  done        out 1         one-cycle pulse on completion
//  vga_x,vga_y out X_W,Y_W   pixel address
//  vga_colour  out COLOUR_W  pixel colour
//  vga_we      out 1         plot strobe
// BEHAVIOUR
//  - Reset values: ready=1, busy=0, done=0, vga_we=0, vga_x=0, vga_y=0, vga_colour=0.
//    State IDLE, counters 0. Reset mid-draw aborts: vga_we=0 and ready=1 from the next cycle.
//  - FSM: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//    IDLE: ready=1. start or clear -> LOAD. start wins if both are high.
//    Requests while busy are ignored, not queued.
//  - LOAD (1 cycle): latch ox,oy,w,h,colour. Clear loads 0,0,SCREEN_W,SCREEN_H,CLR_COLOUR.
//    Counters cx=cy=0. If w==0 or h==0 -> DONE directly, with no writes.
//  - DRAW: one pixel per cycle, cx fastest (row-major).
//    vga_x=ox+cx, vga_y=oy+cy, vga_colour=latched colour.
//    vga_we=1 unless clipped. At cx==w-1: cx<=0, cy<=cy+1.
//    At cx==w-1 && cy==h-1 -> DONE.
//  - Clipping: sums are formed at X_W+1 / Y_W+1 bits. If the sum is >=SCREEN_W or >=SCREEN_H,
//    vga_we=0 but the cycle is still consumed, so timing is independent of position.
//  - DONE (1 cycle): done=1, busy=1 -> IDLE.
//  - Latency: request sampled at cycle 0; first write at cycle 2; last write at cycle w*h+1;
//    done at w*h+2; ready at w*h+3.
//  - vga_* outputs are decoded from registered state/counters only, with no input-to-output
//    paths. vga_x/vga_y/vga_colour hold their last value outside DRAW.
// CONFIGURATION
//  RECT_OUTLINE_EN defined: adds input `outline` (1 bit), latched in LOAD with start.
//    If set, vga_we=1 only for cx==0, cx==w-1, cy==0 or cy==h-1; clipping still applies.
//    Cycle count is unchanged. Clear always fills.
//  RECT_OUTLINE_EN undefined: the `outline` port is absent and every rectangle is filled.
// STRUCTURE
//  draw_pkg: state encoding (IDLE/LOAD/DRAW/DONE), SCREEN_W/SCREEN_H/CLR_COLOUR defaults,
//    coordinate width constants.
//  Sub-module raster_counter #(X_W,Y_W): cx/cy counters with load/enable/wrap and a `last` flag.
//    The FSM and clipping logic stay in rect_draw_ctrl.
// TESTING
//  1 start, x=10 y=20 w=4 h=4 col=5:
//    16 writes at (10..13,20..23), row-major, col 5, cycles 2..17; done @18; ready @19.
//  2 clear:
//    19200 writes, col 0, (0,0)..(159,119) in order; done @19202.
//  3 start x=158 y=118 w=4 h=4:
//    16 DRAW cycles but only 4 writes, (158..159,118..119); done @18.
//  4 start w=0 h=5:
//    no vga_we; done @2; ready @3.
//    Also: start and clear together at cycle 0 -> rectangle drawn, not clear.
//  5 resetn=0 after 5th write of a 4x4 draw:
//    vga_we=0 next cycle, ready=1, no done pulse; a new start then runs normally.
//  6 RECT_OUTLINE_EN, outline=1, x=0 y=0 w=4 h=4:
//    12 writes (4x4 border pixels only, centre 4 skipped); done @18.

Source files
------------

// File: rtl/rect_draw_ctrl_pkg.sv
// rect_draw_ctrl_pkg: shared widths, screen defaults and FSM state encoding for the rectangle plotter
package rect_draw_ctrl_pkg;
  localparam int X_W_DEF = 8;
  localparam int Y_W_DEF = 7;
  localparam int COLOUR_W_DEF = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int CLR_COLOUR_DEF = 0;
  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/rect_draw_ctrl_if.sv
// rect_draw_ctrl_if: request handshake and vga plot port of rect_draw_ctrl
//   master: start, clear, x_in, y_in, w_in, h_in, colour_in (outline when RECT_OUTLINE_EN) out;
//           ready, busy, done, vga_x, vga_y, vga_colour, vga_we in
//   slave:  the same signals with directions reversed
interface rect_draw_ctrl_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3
);
  logic start;
  logic clear;
  logic [X_W-1:0] x_in;
  logic [X_W-1:0] w_in;
  logic [Y_W-1:0] y_in;
  logic [Y_W-1:0] h_in;
  logic [COLOUR_W-1:0] colour_in;
  logic ready;
  logic busy;
  logic done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic vga_we;
`ifdef RECT_OUTLINE_EN
  logic outline;
  modport master (output start, clear, x_in, y_in, w_in, h_in, colour_in, outline,
                  input ready, busy, done, vga_x, vga_y, vga_colour, vga_we);
  modport slave (input start, clear, x_in, y_in, w_in, h_in, colour_in, outline,
                 output ready, busy, done, vga_x, vga_y, vga_colour, vga_we);
`else
  modport master (output start, clear, x_in, y_in, w_in, h_in, colour_in,
                  input ready, busy, done, vga_x, vga_y, vga_colour, vga_we);
  modport slave (input start, clear, x_in, y_in, w_in, h_in, colour_in,
                 output ready, busy, done, vga_x, vga_y, vga_colour, vga_we);
`endif
endinterface

// File: rtl/rect_draw_ctrl_raster_counter.sv
// raster_counter: row-major cx/cy scan counters over a w x h area with a last-pixel flag
//   load_i clears both counters, en_i advances one pixel, last_o marks (w-1, h-1)
module raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
)(
  input  logic           clk,
  input  logic           resetn,
  input  logic           load_i,
  input  logic           en_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W-1:0] cx_o,
  output logic [Y_W-1:0] cy_o,
  output logic           last_o
);
  logic [X_W-1:0] cx_q;
  logic [Y_W-1:0] cy_q;
  logic wrap;
  assign wrap = cx_q == w_i - X_W'(1);
  assign last_o = wrap && (cy_q == h_i - Y_W'(1));
  assign cx_o = cx_q;
  assign cy_o = cy_q;
  always_ff @(posedge clk) begin
    if (!resetn || load_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (en_i) begin
      cx_q <= wrap ? '0 : cx_q + X_W'(1);
      cy_q <= wrap ? cy_q + Y_W'(1) : cy_q;
    end
  end
endmodule

// File: rtl/rect_draw_ctrl.sv
// rect_draw_ctrl: rectangle/clear-screen plotter emitting one clipped pixel write per clock
//   clk, resetn (sync, active-low); bus: rect_draw_ctrl_if.slave (request side + vga plot port)
//   RECT_OUTLINE_EN adds bus.outline: draw only the border of the rectangle
module rect_draw_ctrl
  import rect_draw_ctrl_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int CLR_COLOUR = CLR_COLOUR_DEF
)(
  input logic clk,
  input logic resetn,
  rect_draw_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [X_W-1:0] ox_q, w_q, hx_q, cx;
  logic [Y_W-1:0] oy_q, h_q, hy_q, cy;
  logic [COLOUR_W-1:0] col_q, hc_q;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic accept, draw, last, on_edge, outline_q;
  assign accept = (state_q == S_IDLE) && (bus.start || bus.clear);
  assign draw = state_q == S_DRAW;
  // one extra bit so an origin near the edge plus offset cannot wrap back on screen
  assign px = {1'b0, ox_q} + {1'b0, cx};
  assign py = {1'b0, oy_q} + {1'b0, cy};
  assign on_edge = (cx == '0) || (cx == w_q - X_W'(1)) || (cy == '0) || (cy == h_q - Y_W'(1));
  always_comb begin
    state_d = state_q == S_IDLE ? (accept ? S_LOAD : S_IDLE)
            : state_q == S_LOAD ? ((w_q == '0 || h_q == '0) ? S_DONE : S_DRAW)
            : state_q == S_DRAW ? (last ? S_DONE : S_DRAW)
            : S_IDLE;
  end
  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .load_i (state_q == S_LOAD),
    .en_i   (draw),
    .w_i    (w_q),
    .h_i    (h_q),
    .cx_o   (cx),
    .cy_o   (cy),
    .last_o (last)
  );
  // geometry is captured as the request is accepted so LOAD can test for empty areas
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ox_q <= '0;
      oy_q <= '0;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      hx_q <= '0;
      hy_q <= '0;
      hc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ox_q <= bus.start ? bus.x_in : '0;
        oy_q <= bus.start ? bus.y_in : '0;
        w_q <= bus.start ? bus.w_in : X_W'(SCREEN_W);
        h_q <= bus.start ? bus.h_in : Y_W'(SCREEN_H);
        col_q <= bus.start ? bus.colour_in : COLOUR_W'(CLR_COLOUR);
      end
      if (draw) begin
        hx_q <= px[X_W-1:0];
        hy_q <= py[Y_W-1:0];
        hc_q <= col_q;
      end
    end
  end
`ifdef RECT_OUTLINE_EN
  always_ff @(posedge clk) begin
    if (!resetn) outline_q <= 1'b0;
    else if (accept) outline_q <= bus.start && bus.outline;
  end
`else
  assign outline_q = 1'b0;
`endif
  assign bus.ready = state_q == S_IDLE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE;
  assign bus.vga_we = draw && (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H)) && (!outline_q || on_edge);
  // outside DRAW the plot address shows the last pixel visited
  assign bus.vga_x = draw ? px[X_W-1:0] : hx_q;
  assign bus.vga_y = draw ? py[Y_W-1:0] : hy_q;
  assign bus.vga_colour = draw ? col_q : hc_q;
endmodule
